// File: rtl/mem_bus_responder.sv
// Single-beat memory target: reads/byte-merged writes complete LATENCY cycles after accept, then one turnaround cycle.
// No backpressure: one transaction in flight, mem_req is only sampled in IDLE, and mem_en low during WAIT aborts.
module mem_bus_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_req,
  input  logic        mem_en,
  input  logic        mem_rd_wr,
  input  logic [1:0]  mem_wr_size,
  inout  wire  [31:0] mem_data,
  output logic        mem_data_valid,
  output logic        resp_busy,
  output logic        addr_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RECOV} state_e;

  state_e      state_q, state_d;
  logic [29:0] idx_q, idx_d;
  logic [1:0]  off_q, off_d;
  logic        rd_wr_q, rd_wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic          in_range;
  logic [AW-1:0] word_sel;
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic [2:0]    lane;
  logic          lane_ovf;
  logic          mem_we;

  assign in_range = (idx_q < 30'(MEM_WORDS));
  assign word_sel = idx_q[AW-1:0];
  assign cur_word = mem_q[word_sel];

  // Byte k of the latched data lands in lane off+k; lanes past 3 fall off the word.
  always_comb begin
    merged   = cur_word;
    lane_ovf = 1'b0;
    lane     = '0;
    for (int k = 0; k < 4; k++) begin
      lane = {1'b0, off_q} + 3'(k);
      if (2'(k) <= size_q) begin
        if (lane[2]) begin
          lane_ovf = 1'b1;
        end else begin
          merged[{lane[1:0], 3'b000} +: 8] = wdat_q[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    rd_wr_d = rd_wr_q;
    size_d  = size_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: begin
        if (mem_req && mem_en) begin
          idx_d   = mem_addr[31:2];
          off_d   = mem_addr[1:0];
          rd_wr_d = mem_rd_wr;
          size_d  = mem_wr_size;
          wdat_d  = mem_data;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!mem_en) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = RECOV;
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      rd_wr_q <= 1'b0;
      size_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      rd_wr_q <= rd_wr_d;
      size_q  <= size_d;
      wdat_q  <= wdat_d;
    end
  end

  // Backing store survives reset; a reset already forces IDLE so no commit can slip through.
  assign mem_we = (state_q == RESP) && rd_wr_q && in_range;

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[word_sel] <= merged;
    end
  end

  assign mem_data_valid = (state_q == RESP);
  assign resp_busy      = (state_q != IDLE);
  assign addr_err       = (state_q == RESP) && (!in_range || (rd_wr_q && lane_ovf));
  assign mem_data       = ((state_q == RESP) && !rd_wr_q) ? (in_range ? cur_word : 32'h0) : 32'hz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (LATENCY=4, MEM_WORDS=1024).
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [1:0]  mem_wr_size;
  wire  [31:0] mem_data;
  logic        mem_data_valid;
  logic        resp_busy;
  logic        addr_err;

  logic        tb_drv;
  logic [31:0] tb_wdat;

  int checks = 0;
  int errors = 0;

  assign mem_data = tb_drv ? tb_wdat : 32'hz;

  always #5 clk = ~clk;

  mem_bus_responder #(.MEM_WORDS(1024), .LATENCY(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_en        (mem_en),
    .mem_rd_wr     (mem_rd_wr),
    .mem_wr_size   (mem_wr_size),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .resp_busy     (resp_busy),
    .addr_err      (addr_err)
  );

  // An undriven bus reads as Z on 4-state simulators and as 0 on 2-state ones.
  function automatic logic released(input logic [31:0] v);
    return (v === 32'hz) || (v === 32'h0);
  endfunction

  // Issues one beat from IDLE and observes the following 8 cycles.
  task automatic bus_txn(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                         input logic [31:0] wdat, output logic [31:0] rdat,
                         output int vcnt, output int ecnt);
    rdat = '0;
    vcnt = 0;
    ecnt = 0;
    @(negedge clk);
    mem_addr    = addr;
    mem_rd_wr   = rw;
    mem_wr_size = size;
    tb_wdat     = wdat;
    tb_drv      = rw;
    mem_req     = 1'b1;
    mem_en      = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_data_valid) begin
        vcnt++;
        rdat = mem_data;
      end
      if (addr_err) ecnt++;
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (mem_data_valid !== 1'b0 || resp_busy !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b err=%b want 0 0 0", mem_data_valid, resp_busy, addr_err);
    end
    checks++;
    if (!released(mem_data)) begin
      errors++;
      $display("FAIL reset_bus: got %h want high-Z", mem_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd;
    int v, e;
    bus_txn(32'h40, 1'b1, 2'b11, 32'hDEADBEEF, rd, v, e);
    @(negedge clk);
    mem_addr  = 32'h40;
    mem_rd_wr = 1'b0;
    mem_req   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (mem_data_valid !== (c == 4)) begin
        errors++;
        $display("FAIL rd_valid_c%0d: got %b want %b", c, mem_data_valid, (c == 4));
      end
      checks++;
      if (resp_busy !== (c <= 5)) begin
        errors++;
        $display("FAIL rd_busy_c%0d: got %b want %b", c, resp_busy, (c <= 5));
      end
      checks++;
      if (c == 4) begin
        if (mem_data !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rd_data: got %h want deadbeef", mem_data);
        end
      end else if (!released(mem_data)) begin
        errors++;
        $display("FAIL rd_bus_c%0d: got %h want high-Z", c, mem_data);
      end
      if (c == 1) mem_req = 1'b0;
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd;
    int v, e;
    bus_txn(32'h100, 1'b1, 2'b11, 32'h11223344, rd, v, e);
    bus_txn(32'h101, 1'b1, 2'b01, 32'h0000AABB, rd, v, e);
    checks++;
    if (v !== 1 || e !== 0) begin
      errors++;
      $display("FAIL merge_wr_pulses: got valid=%0d err=%0d want 1 0", v, e);
    end
    bus_txn(32'h100, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'h11AABB44 || v !== 1 || e !== 0) begin
      errors++;
      $display("FAIL merge_readback: got %h v=%0d e=%0d want 11aabb44 1 0", rd, v, e);
    end
  endtask

  task automatic test_word_cross();
    logic [31:0] rd;
    int v, e;
    bus_txn(32'h200, 1'b1, 2'b11, 32'h01020304, rd, v, e);
    bus_txn(32'h204, 1'b1, 2'b11, 32'h55667788, rd, v, e);
    bus_txn(32'h203, 1'b1, 2'b10, 32'h00CCDDEE, rd, v, e);
    checks++;
    if (v !== 1 || e !== 1) begin
      errors++;
      $display("FAIL cross_pulses: got valid=%0d err=%0d want 1 1", v, e);
    end
    bus_txn(32'h200, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'hEE020304) begin
      errors++;
      $display("FAIL cross_word: got %h want ee020304", rd);
    end
    bus_txn(32'h204, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'h55667788) begin
      errors++;
      $display("FAIL cross_neighbour: got %h want 55667788", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d1, d2;
    int v, e, n, first, second;
    bus_txn(32'h10, 1'b1, 2'b11, 32'hA5A50010, rd, v, e);
    bus_txn(32'h14, 1'b1, 2'b11, 32'h5A5A0014, rd, v, e);
    n = 0; first = -1; second = -1; d1 = '0; d2 = '0;
    @(negedge clk);
    mem_addr  = 32'h10;
    mem_rd_wr = 1'b0;
    mem_req   = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_data_valid) begin
        n++;
        if (n == 1) begin
          first    = c;
          d1       = mem_data;
          mem_addr = 32'h14;
        end else if (n == 2) begin
          second  = c;
          d2      = mem_data;
          mem_req = 1'b0;
        end
      end
    end
    mem_req = 1'b0;
    checks++;
    if (n !== 2 || (second - first) !== 6) begin
      errors++;
      $display("FAIL b2b_timing: got pulses=%0d gap=%0d want 2 6", n, second - first);
    end
    checks++;
    if (d1 !== 32'hA5A50010 || d2 !== 32'h5A5A0014) begin
      errors++;
      $display("FAIL b2b_data: got %h %h want a5a50010 5a5a0014", d1, d2);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int v, e, nv, ne;
    bus_txn(32'h20, 1'b1, 2'b11, 32'h0BADF00D, rd, v, e);
    nv = 0; ne = 0;
    @(negedge clk);
    mem_addr    = 32'h20;
    mem_rd_wr   = 1'b1;
    mem_wr_size = 2'b11;
    tb_wdat     = 32'hFFFFFFFF;
    tb_drv      = 1'b1;
    mem_req     = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b want 0", resp_busy);
    end
    for (int c = 0; c < 8; c++) begin
      if (mem_data_valid) nv++;
      if (addr_err) ne++;
      @(negedge clk);
    end
    tb_drv = 1'b0;
    mem_en = 1'b1;
    checks++;
    if (nv !== 0 || ne !== 0) begin
      errors++;
      $display("FAIL abort_pulses: got valid=%0d err=%0d want 0 0", nv, ne);
    end
    bus_txn(32'h20, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL abort_readback: got %h want 0badf00d", rd);
    end
  endtask

  task automatic test_range_bounds();
    logic [31:0] rd;
    int v, e;
    bus_txn(32'hFFC, 1'b1, 2'b11, 32'hCAFEF00D, rd, v, e);
    bus_txn(32'hFFC, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 0) begin
      errors++;
      $display("FAIL last_word: got %h err=%0d want cafef00d 0", rd, e);
    end
    bus_txn(32'h1000, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'h0 || v !== 1 || e !== 1) begin
      errors++;
      $display("FAIL oob_read: got %h v=%0d e=%0d want 0 1 1", rd, v, e);
    end
    bus_txn(32'h1040, 1'b1, 2'b11, 32'h12345678, rd, v, e);
    checks++;
    if (v !== 1 || e !== 1) begin
      errors++;
      $display("FAIL oob_write: got valid=%0d err=%0d want 1 1", v, e);
    end
    bus_txn(32'h40, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oob_no_commit: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int v, e, nv, ne;
    nv = 0; ne = 0;
    @(negedge clk);
    mem_addr  = 32'h10000;
    mem_rd_wr = 1'b0;
    mem_req   = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait: got busy=%b want 1", resp_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (resp_busy !== 1'b0 || mem_data_valid !== 1'b0 || addr_err !== 1'b0 || !released(mem_data)) begin
      errors++;
      $display("FAIL rstmid_async: got busy=%b valid=%b err=%b data=%h want 0 0 0 Z",
               resp_busy, mem_data_valid, addr_err, mem_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_data_valid) nv++;
      if (addr_err) ne++;
    end
    checks++;
    if (nv !== 0 || ne !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses: got valid=%0d err=%0d want 0 0", nv, ne);
    end
    bus_txn(32'h40, 1'b0, 2'b00, 32'h0, rd, v, e);
    checks++;
    if (rd !== 32'hDEADBEEF || v !== 1 || e !== 0) begin
      errors++;
      $display("FAIL rstmid_recover: got %h v=%0d e=%0d want deadbeef 1 0", rd, v, e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    mem_addr    = '0;
    mem_req     = 1'b0;
    mem_en      = 1'b1;
    mem_rd_wr   = 1'b0;
    mem_wr_size = 2'b00;
    tb_drv      = 1'b0;
    tb_wdat     = '0;
    test_reset();
    test_read_latency();
    test_write_merge();
    test_word_cross();
    test_back_to_back();
    test_abort();
    test_range_bounds();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
